mu0_boot_arbiter: RTL

- Sequences MU0 start-up and owns the single port of memory_32x16.
- After reset it holds MU0 in reset and streams a program/data image from a loader interface into memory, one word per cycle, from address 0.
- It then waits a fixed number of quiet cycles, releases MU0 reset, and passes the memory port through to MU0.
- A boot_req pulse re-enters the load phase at any time.

---
 rtl/mu0_boot_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mu0_boot_arbiter.sv
// Boot sequencer for MU0: streams a loader image into the single-port memory,
// holds the CPU in reset for a few quiet cycles, then hands the memory port to the CPU.
module mu0_boot_arbiter #(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_req,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_memrq,
    input  logic              cpu_rnw,
    output logic              cpu_rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_memrq,
    output logic              mem_rnw,
    output logic              boot_done,
    output logic [ADDR_W-1:0] load_count,
    output logic              load_ovf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [ADDR_W-1:0] load_count_reg, load_count_next;
    logic              load_ovf_reg, load_ovf_next;
    logic              ld_ready_reg, ld_ready_next;
    logic              cpu_rst_n_reg, cpu_rst_n_next;
    logic              accept;
    logic              ptr_at_end;

    // A boot_req cycle never writes, so a pending handshake is dropped.
    assign accept     = (state_reg == LOAD) && ld_ready_reg && ld_valid && !boot_req;
    assign ptr_at_end = (wr_ptr_reg == PTR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= LOAD;
            wr_ptr_reg     <= '0;
            hold_cnt_reg   <= '0;
            load_count_reg <= '0;
            load_ovf_reg   <= 1'b0;
            ld_ready_reg   <= 1'b0;
            cpu_rst_n_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            hold_cnt_reg   <= hold_cnt_next;
            load_count_reg <= load_count_next;
            load_ovf_reg   <= load_ovf_next;
            ld_ready_reg   <= ld_ready_next;
            cpu_rst_n_reg  <= cpu_rst_n_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        hold_cnt_next   = hold_cnt_reg;
        load_count_next = load_count_reg;
        load_ovf_next   = load_ovf_reg;

        case (state_reg)
            LOAD: begin
                if (accept) begin
                    wr_ptr_next     = wr_ptr_reg + PTR_W'(1);
                    load_count_next = load_count_reg + ADDR_W'(1);
                    if (ld_last || ptr_at_end) begin
                        state_next    = HOLD;
                        hold_cnt_next = '0;
                        load_ovf_next = ptr_at_end && !ld_last;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_next = RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = LOAD;
            end
        endcase

        // Restart wins over every other transition, from any state.
        if (boot_req) begin
            state_next      = LOAD;
            wr_ptr_next     = '0;
            hold_cnt_next   = '0;
            load_count_next = '0;
            load_ovf_next   = 1'b0;
        end

        ld_ready_next  = (state_next == LOAD);
        cpu_rst_n_next = (state_next == RUN);
    end

    // Memory port mux: CPU owns it in RUN, the loader only on accept cycles.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_memrq = 1'b0;
        mem_rnw   = 1'b1;
        if (state_reg == RUN) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_memrq = cpu_memrq;
            mem_rnw   = cpu_rnw;
        end else if (accept) begin
            mem_addr  = ADDR_W'(wr_ptr_reg);
            mem_wdata = ld_data;
            mem_memrq = 1'b1;
            mem_rnw   = 1'b0;
        end
    end

    assign ld_ready   = ld_ready_reg;
    assign cpu_rst_n  = cpu_rst_n_reg;
    assign boot_done  = (state_reg == RUN);
    assign load_count = load_count_reg;
    assign load_ovf   = load_ovf_reg;

endmodule
